// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: 64-bit RISC-V execute slice. Resolves operand forwarding,
// decodes the ALU operation, computes the ALU result and the branch target,
// and holds the EX/MEM pipeline register feeding the memory-access stage.
module ex_stage_pipe #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic [REGW-1:0] rd,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [1:0]      alu_op,
  input  logic            alu_src,
  input  logic            branch,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic            wb_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_zero,
  output logic [XLEN-1:0] pc_branch,
  output logic            branch_q,
  output logic            mem_read_q,
  output logic            mem_write_q,
  output logic            mem_to_reg_q,
  output logic            reg_write_q,
  output logic [XLEN-1:0] pc_branch_q,
  output logic [XLEN-1:0] alu_result_q,
  output logic [XLEN-1:0] rs2_data_q,
  output logic            alu_zero_q,
  output logic [REGW-1:0] rd_q
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [5:0]      shamt;

  // Forwarding selects: the younger EX/MEM producer wins over MEM/WB; x0 never forwards.
  always_comb begin
    forward_a = 2'b00;
    if (reg_write_q && (rd_q != '0) && (rd_q == rs1))
      forward_a = 2'b10;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1))
      forward_a = 2'b01;

    forward_b = 2'b00;
    if (reg_write_q && (rd_q != '0) && (rd_q == rs2))
      forward_b = 2'b10;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2))
      forward_b = 2'b01;
  end

  // Operand muxes; select 11 is unused and falls back to the ID/EX value.
  always_comb begin
    case (forward_a)
      2'b10:   op_a = alu_result_q;
      2'b01:   op_a = wb_data;
      default: op_a = rs1_data;
    endcase
    case (forward_b)
      2'b10:   fwd_b = alu_result_q;
      2'b01:   fwd_b = wb_data;
      default: fwd_b = rs2_data;
    endcase
    op_b = alu_src ? imm : fwd_b;
  end

  // ALU control decode from the main-decoder class and funct fields.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (funct3)
          // Immediate forms (addi) reuse bit 30 as part of the immediate, so only R-type subtracts.
          3'b000:  alu_ctrl = (funct7b5 && !alu_src) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  assign shamt = op_b[5:0];

  // ALU datapath; unassigned control codes yield zero.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_SLL:  alu_result = op_a << shamt;
      ALU_SRL:  alu_result = op_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  alu_result = '0;
    endcase
  end

  assign alu_zero  = (alu_result == '0);
  assign pc_branch = pc + (imm << 1);

  // EX/MEM register: captures every cycle, reset clears everything including rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      pc_branch_q  <= '0;
      alu_result_q <= '0;
      rs2_data_q   <= '0;
      alu_zero_q   <= 1'b0;
      rd_q         <= '0;
    end else begin
      branch_q     <= branch;
      mem_read_q   <= mem_read;
      mem_write_q  <= mem_write;
      mem_to_reg_q <= mem_to_reg;
      reg_write_q  <= reg_write;
      pc_branch_q  <= pc_branch;
      alu_result_q <= alu_result;
      rs2_data_q   <= fwd_b;
      alu_zero_q   <= alu_zero;
      rd_q         <= rd;
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed cases plus randomized traffic checked against a
// behavioural model of the execute slice and its EX/MEM register.
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc, rs1_data, rs2_data, imm, wb_data;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic [2:0]  funct3;
  logic        funct7b5, alu_src, branch, mem_read, mem_write, mem_to_reg, reg_write, wb_reg_write;
  logic [1:0]  alu_op;
  logic [1:0]  forward_a, forward_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_result, pc_branch, pc_branch_q, alu_result_q, rs2_data_q;
  logic        alu_zero, branch_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q, alu_zero_q;
  logic [4:0]  rd_q;

  int total = 0;
  int bad   = 0;

  ex_stage_pipe #(.XLEN(64), .REGW(5)) dut (
    .clk(clk), .rst(rst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7b5(funct7b5), .alu_op(alu_op),
    .alu_src(alu_src), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .forward_a(forward_a), .forward_b(forward_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero), .pc_branch(pc_branch),
    .branch_q(branch_q), .mem_read_q(mem_read_q), .mem_write_q(mem_write_q),
    .mem_to_reg_q(mem_to_reg_q), .reg_write_q(reg_write_q), .pc_branch_q(pc_branch_q),
    .alu_result_q(alu_result_q), .rs2_data_q(rs2_data_q), .alu_zero_q(alu_zero_q), .rd_q(rd_q)
  );

  always #5 clk = ~clk;

  // Model of the EX/MEM contents: what the previous instruction left behind.
  bit          m_valid = 0;
  logic [4:0]  m_ctl;   // {branch, mem_read, mem_write, mem_to_reg, reg_write}
  logic [63:0] m_pcb, m_res, m_store;
  logic        m_zero;
  logic [4:0]  m_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Operation chosen by the instruction, named as in the ISA.
  function automatic string op_name(input logic [1:0] aop, input logic [2:0] f3,
                                    input logic f7, input logic asrc);
    if (aop == 2'd1) return "SUB";
    if (aop != 2'd2) return "ADD";
    case (f3)
      3'd0: return (f7 && !asrc) ? "SUB" : "ADD";
      3'd1: return "SLL";
      3'd2: return "SLT";
      3'd3: return "SLTU";
      3'd4: return "XOR";
      3'd5: return f7 ? "SRA" : "SRL";
      3'd6: return "OR";
      default: return "AND";
    endcase
  endfunction

  function automatic logic [3:0] op_code(input string n);
    case (n)
      "AND": return 4'd0;  "OR":  return 4'd1;  "ADD": return 4'd2;  "XOR": return 4'd3;
      "SLL": return 4'd4;  "SRL": return 4'd5;  "SUB": return 4'd6;  "SRA": return 4'd7;
      "SLT": return 4'd8;  default: return 4'd9;
    endcase
  endfunction

  function automatic logic [63:0] op_eval(input string n, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    int sh;
    sa = a; sb = b; sh = int'(b % 64);
    case (n)
      "AND": return a & b;
      "OR":  return a | b;
      "ADD": return a + b;
      "SUB": return a - b;
      "XOR": return a ^ b;
      "SLL": return a << sh;
      "SRL": return a >> sh;
      "SRA": return sa >>> sh;
      "SLT": return (sa < sb) ? 64'd1 : 64'd0;
      default: return (a < b) ? 64'd1 : 64'd0;
    endcase
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (m_ctl[0] && m_rd != 0 && m_rd == src) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [63:0] fwd_val(input logic [1:0] sel, input logic [63:0] id_val);
    if (sel == 2'b10) return m_res;
    if (sel == 2'b01) return wb_data;
    return id_val;
  endfunction

  // One instruction through EX: check combinational outputs, clock, check the register.
  task automatic do_cycle();
    logic [1:0]  fa, fb;
    logic [63:0] a, b_fwd, b, res, pcb;
    string       n;
    #1;
    fa = fwd_sel(rs1);
    fb = fwd_sel(rs2);
    a = fwd_val(fa, rs1_data);
    b_fwd = fwd_val(fb, rs2_data);
    b = alu_src ? imm : b_fwd;
    n = op_name(alu_op, funct3, funct7b5, alu_src);
    res = op_eval(n, a, b);
    pcb = pc + imm * 2;
    if (m_valid) begin
      check("forward_a", {62'd0, forward_a}, {62'd0, fa});
      check("forward_b", {62'd0, forward_b}, {62'd0, fb});
      check("alu_ctrl", {60'd0, alu_ctrl}, {60'd0, op_code(n)});
      check("alu_result", alu_result, res);
      check("alu_zero", {63'd0, alu_zero}, {63'd0, res == 0});
    end
    check("pc_branch", pc_branch, pcb);
    @(posedge clk);
    #1;
    if (rst) begin
      m_ctl = 0; m_pcb = 0; m_res = 0; m_store = 0; m_zero = 0; m_rd = 0;
      m_valid = 1;
    end else begin
      m_ctl = {branch, mem_read, mem_write, mem_to_reg, reg_write};
      m_pcb = pcb; m_res = res; m_store = b_fwd; m_zero = (res == 0); m_rd = rd;
    end
    if (m_valid) begin
      check("ctl_q", {59'd0, branch_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q},
            {59'd0, m_ctl});
      check("pc_branch_q", pc_branch_q, m_pcb);
      check("alu_result_q", alu_result_q, m_res);
      check("rs2_data_q", rs2_data_q, m_store);
      check("zero_rd_q", {58'd0, alu_zero_q, rd_q}, {58'd0, m_zero, m_rd});
    end
    $display("cycle rst=%0d op=%s a_sel=%0d b_sel=%0d result=0x%016h", rst, n, fa, fb, res);
  endtask

  task automatic clear_inputs();
    rst = 0; pc = 0; rs1_data = 0; rs2_data = 0; imm = 0; wb_data = 0;
    rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0; funct3 = 0; funct7b5 = 0; alu_op = 0;
    alu_src = 0; branch = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    reg_write = 0; wb_reg_write = 0;
  endtask

  task automatic randomize_inputs();
    pc = {$urandom, $urandom}; imm = {$urandom, $urandom}; wb_data = {$urandom, $urandom};
    rs1_data = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 4)) : {$urandom, $urandom};
    rs2_data = ($urandom_range(0, 3) == 0) ? rs1_data : {$urandom, $urandom};
    rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
    funct3 = 3'($urandom); funct7b5 = 1'($urandom); alu_op = 2'($urandom);
    alu_src = 1'($urandom); branch = 1'($urandom); mem_read = 1'($urandom);
    mem_write = 1'($urandom); mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
    wb_reg_write = 1'($urandom);
  endtask

  initial begin
    // Reset with nonzero inputs clears every registered output.
    randomize_inputs();
    reg_write = 1; rd = 5'd7;
    rst = 1;
    do_cycle();
    check("reset_all_q", {alu_result_q | pc_branch_q | rs2_data_q},  64'd0);

    // ADD 7 + 5.
    clear_inputs();
    alu_op = 2'b10; rs1_data = 7; rs2_data = 5;
    #1;
    check("add_result", alu_result, 64'd12);
    check("add_ctrl", {60'd0, alu_ctrl}, 64'd2);
    do_cycle();
    check("add_result_q", alu_result_q, 64'd12);

    // SUB to zero plus branch target.
    clear_inputs();
    alu_op = 2'b01; rs1_data = 9; rs2_data = 9; pc = 64'h100; imm = 8;
    #1;
    check("sub_zero", {63'd0, alu_zero}, 64'd1);
    check("sub_pcb", pc_branch, 64'h110);
    do_cycle();
    check("sub_pcb_q", pc_branch_q, 64'h110);

    // EX/MEM forwarding into operand A.
    clear_inputs();
    rd = 3; reg_write = 1; rs1_data = 12; rs2_data = 8;
    do_cycle();
    clear_inputs();
    rs1 = 3; rs1_data = 1; alu_src = 1; imm = 4;
    #1;
    check("exmem_fwd_a", {62'd0, forward_a}, 64'd2);
    check("exmem_fwd_res", alu_result, 64'd24);
    do_cycle();

    // Both stages match rs2: EX/MEM wins. This producer targets x0.
    clear_inputs();
    rd = 2; reg_write = 1;
    do_cycle();
    clear_inputs();
    rs2 = 2; wb_reg_write = 1; wb_rd = 2; wb_data = 64'h55; rd = 0; reg_write = 1;
    #1;
    check("prio_fwd_b", {62'd0, forward_b}, 64'd2);
    do_cycle();
    clear_inputs();
    rs2 = 2; wb_reg_write = 1; wb_rd = 2; wb_data = 64'h55; alu_src = 1; imm = 64'h9;
    #1;
    check("x0_fwd_b", {62'd0, forward_b}, 64'd1);
    do_cycle();
    check("store_q", rs2_data_q, 64'h55);

    // Shifts and compares.
    clear_inputs();
    alu_op = 2'b10; funct3 = 3'b101; funct7b5 = 1; rs1_data = -64'sd16; rs2_data = 2;
    #1; check("sra", alu_result, -64'sd4);
    funct7b5 = 0;
    #1; check("srl", alu_result, 64'h3FFF_FFFF_FFFF_FFFC);
    funct3 = 3'b010; rs1_data = '1; rs2_data = 1;
    #1; check("slt", alu_result, 64'd1);
    funct3 = 3'b011;
    #1; check("sltu", alu_result, 64'd0);
    do_cycle();

    // addi with bit 30 set by a negative immediate stays ADD.
    clear_inputs();
    alu_op = 2'b10; alu_src = 1; funct7b5 = 1; imm = -64'sd3; rs1_data = 10;
    #1; check("addi_neg", alu_result, 64'd7);
    do_cycle();

    // Random traffic with occasional mid-stream reset.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 19) == 0);
      do_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage_pipe.md
Name: ex_stage_pipe

Overview:
- 64-bit RISC-V execute slice: operand forwarding, ALU control decode, ALU, branch-target adder, and the EX/MEM pipeline register.
- Sits between the ID/EX register and the memory-access stage.
- Forwarding selects between ID/EX operands, its own registered EX/MEM result, and the MEM/WB write-back value.

Parameters:
XLEN, 64, data/address width
REGW, 5, register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc  in  XLEN  PC of instruction in EX
rs1_data  in  XLEN  ID/EX rs1 value
rs2_data  in  XLEN  ID/EX rs2 value
imm  in  XLEN  sign-extended immediate
rs1, rs2, rd  in  REGW each  ID/EX register indices
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
alu_op  in  2  main-decoder ALU class
alu_src  in  1  1 = operand B is imm
branch, mem_read, mem_write, mem_to_reg, reg_write  in  1 each  ID/EX control bits
wb_reg_write  in  1  MEM/WB reg_write
wb_rd  in  REGW  MEM/WB destination
wb_data  in  XLEN  MEM/WB write-back value
forward_a, forward_b  out  2 each  forwarding selects (combinational)
alu_ctrl  out  4  decoded ALU operation (combinational)
alu_result  out  XLEN  combinational ALU result
alu_zero  out  1  alu_result == 0
pc_branch  out  XLEN  combinational branch target
branch_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q  out  1 each  registered controls
pc_branch_q, alu_result_q, rs2_data_q  out  XLEN each  registered values
alu_zero_q  out  1  registered zero flag
rd_q  out  REGW  registered destination

Behaviour:
Forwarding (combinational)
- forward_a = 10 if reg_write_q && rd_q != 0 && rd_q == rs1.
- Else 01 if wb_reg_write && wb_rd != 0 && wb_rd == rs1.
- Else 00.
- forward_b: same rules using rs2.
- EX/MEM has priority over MEM/WB when both match.
- Operand selects: 00 = ID/EX data, 10 = alu_result_q, 01 = wb_data, 11 = ID/EX data.
- opA = forwarded rs1.
- fwdB = forwarded rs2.
- opB = alu_src ? imm : fwdB.

ALU control
- alu_op 00 -> ADD; 01 -> SUB; 11 -> ADD.
- alu_op 10, by funct3:
  - 000: SUB if funct7b5 && !alu_src, else ADD.
  - 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7b5 else SRL; 110 OR; 111 AND.
- alu_ctrl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, XOR 0011, SLL 0100, SRL 0101, SRA 0111, SLT 1000, SLTU 1001.
- Unused codes produce 0.

ALU (combinational)
- Two's-complement XLEN-bit wrap-around, no overflow flag.
- Shift amount = opB[5:0].
- SLT signed, SLTU unsigned; result is 0 or 1.
- alu_zero = (alu_result == 0).
- pc_branch = pc + (imm << 1), modulo 2^XLEN.

EX/MEM register
- On posedge clk with rst = 1: every *_q output becomes 0, including rd_q.
- Otherwise captures the inputs every cycle:
  - controls as given;
  - pc_branch, alu_result, alu_zero, rd;
  - rs2_data_q = fwdB (forwarded store data, not imm).
- No stall/enable; latency is exactly 1 cycle.
- Reset has priority over capture, including reset asserted mid-stream.
- After reset, reg_write_q = 0, so no EX/MEM forwarding occurs.
- rd = 0 never forwards even when reg_write is set; x0 reads keep the ID/EX value.

Test Plan:
- Reset: rst = 1 for 1 clk with nonzero inputs -> all *_q = 0. Then rst = 0, alu_op = 10, funct3 = 000, rs1_data = 7, rs2_data = 5 -> alu_result = 12, alu_ctrl = 0010; next edge alu_result_q = 12.
- SUB/zero/branch: alu_op = 01, rs1_data = rs2_data = 9, pc = 0x100, imm = 8 -> alu_result = 0, alu_zero = 1, pc_branch = 0x110; after clk alu_zero_q = 1, pc_branch_q = 0x110.
- EX/MEM forward: cycle 1 rd = 3, reg_write = 1, result 20. Cycle 2 rs1 = 3, rs1_data = 1, alu_op = 00, alu_src = 1, imm = 4 -> forward_a = 10, alu_result = 24.
- Priority and MEM/WB forwarding:
  - reg_write_q with rd_q = 2 and wb_reg_write with wb_rd = 2 both match -> forward_b = 10.
  - With rd_q = 0 (x0, never forwards) -> forward_b = 01 and fwdB = wb_data = 0x55; rs2_data_q captures 0x55.
- Ops: funct3 101 with funct7b5 = 1, rs1_data = -16, rs2_data = 2 -> -4; funct7b5 = 0 -> 0x3FFF_FFFF_FFFF_FFFC. SLT(-1, 1) = 1; SLTU(-1, 1) = 0.
- addi with negative imm (alu_op = 10, alu_src = 1, funct7b5 = 1, imm = -3, rs1_data = 10) -> 7 (ADD, not SUB).
